// File: rtl/ofifo_drain.sv
// ofifo_drain: drains a programmed number of psum rows from the output FIFO
// behind mac_array and writes them into a psum SRAM at consecutive addresses.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       1-cycle job request, sampled only when idle
//   num_rows    rows to drain (0..2^addr_w), latched on start
//   base_addr   first SRAM address, latched on start
//   fifo_valid  FIFO head row present on fifo_out
//   fifo_out    FIFO head row, lane c at [c*bw_psum +: bw_psum]
//   fifo_rd     pop strobe (combinational from state and fifo_valid)
//   pmem_cen    SRAM chip enable, active-low
//   pmem_wen    SRAM write enable, active-low
//   pmem_a      SRAM address (wraps modulo 2^addr_w)
//   pmem_d      SRAM write data
//   busy        high whenever a job is in progress (any state but idle)
//   done        1-cycle completion pulse
//   rows_done   rows written in the current/last job
//
// Configuration macro
//   RELU_EN     when defined, negative lanes are clamped to zero on the way
//               into pmem_d; otherwise pmem_d is a bit-exact copy of fifo_out.

module ofifo_drain #(
    parameter int unsigned bw_psum = 20,
    parameter int unsigned col     = 8,
    parameter int unsigned addr_w  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_w:0]          num_rows,
    input  logic [addr_w-1:0]        base_addr,
    input  logic                     fifo_valid,
    input  logic [bw_psum*col-1:0]   fifo_out,
    output logic                     fifo_rd,
    output logic                     pmem_cen,
    output logic                     pmem_wen,
    output logic [addr_w-1:0]        pmem_a,
    output logic [bw_psum*col-1:0]   pmem_d,
    output logic                     busy,
    output logic                     done,
    output logic [addr_w:0]          rows_done
);

    localparam int unsigned row_w = bw_psum * col;
    localparam int unsigned cnt_w = addr_w + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [cnt_w-1:0]   num_q, num_d;
    logic [addr_w-1:0]  base_q, base_d;
    logic [cnt_w-1:0]   rows_done_q, rows_done_d;
    logic               pmem_cen_q, pmem_cen_d;
    logic               pmem_wen_q, pmem_wen_d;
    logic [addr_w-1:0]  pmem_a_q, pmem_a_d;
    logic [row_w-1:0]   pmem_d_q, pmem_d_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [row_w-1:0]   wr_row;

    // Pop whenever draining and the FIFO has a head row; the FSM leaves DRAIN
    // on the last pop, so no extra pop can follow.
    always_comb begin
        fifo_rd = (state_q == ST_DRAIN) && fifo_valid;
    end

    // Row as it will be written to the SRAM.
    always_comb begin
        wr_row = fifo_out;
`ifdef RELU_EN
        for (int unsigned c = 0; c < col; c++) begin
            if (fifo_out[c*bw_psum + bw_psum - 1]) begin
                wr_row[c*bw_psum +: bw_psum] = '0;
            end
        end
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        base_d      = base_q;
        rows_done_d = rows_done_q;
        pmem_cen_d  = 1'b1;
        pmem_wen_d  = 1'b1;
        pmem_a_d    = pmem_a_q;
        pmem_d_d    = pmem_d_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d       = num_rows;
                    base_d      = base_addr;
                    rows_done_d = '0;
                    state_d     = (num_rows == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_rd) begin
                    pmem_cen_d  = 1'b0;
                    pmem_wen_d  = 1'b0;
                    // Address wraps naturally at addr_w bits.
                    pmem_a_d    = base_q + rows_done_q[addr_w-1:0];
                    pmem_d_d    = wr_row;
                    rows_done_d = rows_done_q + cnt_w'(1);
                    if (rows_done_d == num_q) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            // Last write is captured by the SRAM during this cycle.
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            num_q       <= '0;
            base_q      <= '0;
            rows_done_q <= '0;
            pmem_cen_q  <= 1'b1;
            pmem_wen_q  <= 1'b1;
            pmem_a_q    <= '0;
            pmem_d_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            base_q      <= base_d;
            rows_done_q <= rows_done_d;
            pmem_cen_q  <= pmem_cen_d;
            pmem_wen_q  <= pmem_wen_d;
            pmem_a_q    <= pmem_a_d;
            pmem_d_q    <= pmem_d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pmem_cen  = pmem_cen_q;
    assign pmem_wen  = pmem_wen_q;
    assign pmem_a    = pmem_a_q;
    assign pmem_d    = pmem_d_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rows_done = rows_done_q;

endmodule

// File: tb/tb_ofifo_drain.sv
// Testbench for ofifo_drain: directed jobs with a job-level reference model
// compared every cycle, plus hand-computed expectations per scenario.

module tb_ofifo_drain;

    localparam int unsigned BW  = 20;
    localparam int unsigned COL = 8;
    localparam int unsigned AW  = 4;
    localparam int unsigned NW  = AW + 1;
    localparam int unsigned RW  = BW * COL;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] num_rows = '0;
    logic [AW-1:0] base_addr = '0;
    logic          fifo_valid = 1'b0;
    logic [RW-1:0] fifo_out = '0;
    logic          fifo_rd;
    logic          pmem_cen;
    logic          pmem_wen;
    logic [AW-1:0] pmem_a;
    logic [RW-1:0] pmem_d;
    logic          busy;
    logic          done;
    logic [NW-1:0] rows_done;

    ofifo_drain #(.bw_psum(BW), .col(COL), .addr_w(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .base_addr(base_addr), .fifo_valid(fifo_valid), .fifo_out(fifo_out),
        .fifo_rd(fifo_rd), .pmem_cen(pmem_cen), .pmem_wen(pmem_wen),
        .pmem_a(pmem_a), .pmem_d(pmem_d), .busy(busy), .done(done),
        .rows_done(rows_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic chki(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic logic [RW-1:0] relu(input logic [RW-1:0] r);
`ifdef RELU_EN
        for (int c = 0; c < COL; c++) begin
            if (r[c*BW + BW - 1]) r[c*BW +: BW] = '0;
        end
`endif
        return r;
    endfunction

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        for (int i = 0; i < RW; i += 32) r[i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [RW-1:0] mk_row(input int v);
        logic [RW-1:0] r;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(v + c);
        return r;
    endfunction

    // ---------------- job-level reference model ----------------
    longint        cyc = 0;
    bit            m_job = 1'b0;
    int            m_num = 0;
    int            m_base = 0;
    int            m_pops = 0;
    longint        m_done_at = -10;
    logic          e_cen = 1'b1;
    logic          e_wen = 1'b1;
    logic [AW-1:0] e_a = '0;
    logic [RW-1:0] e_d = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_job = 1'b0; m_num = 0; m_base = 0; m_pops = 0; m_done_at = -10;
            e_cen = 1'b1; e_wen = 1'b1; e_a = '0; e_d = '0;
        end else begin
            cyc++;
            if (m_job && m_pops < m_num && fifo_valid) begin
                e_cen = 1'b0; e_wen = 1'b0;
                e_a = AW'(m_base + m_pops);
                e_d = relu(fifo_out);
                m_pops++;
                if (m_pops == m_num) m_done_at = cyc + 1;
            end else begin
                e_cen = 1'b1; e_wen = 1'b1;
            end
            if (m_job && cyc == m_done_at + 1) begin
                m_job = 1'b0;
            end else if (!m_job && start) begin
                m_job = 1'b1; m_num = int'(num_rows); m_base = int'(base_addr); m_pops = 0;
                m_done_at = (num_rows == '0) ? cyc : 64'd1_000_000_000;
            end
        end
    end

    // Single compare process, every cycle.
    always @(negedge clk) begin
        chk("fifo_rd",   RW'(fifo_rd),   RW'(m_job && m_pops < m_num && fifo_valid));
        chk("pmem_cen",  RW'(pmem_cen),  RW'(e_cen));
        chk("pmem_wen",  RW'(pmem_wen),  RW'(e_wen));
        chk("pmem_a",    RW'(pmem_a),    RW'(e_a));
        chk("pmem_d",    pmem_d,         e_d);
        chk("busy",      RW'(busy),      RW'(m_job));
        chk("done",      RW'(done),      RW'(m_job && cyc == m_done_at));
        chk("rows_done", RW'(rows_done), RW'(m_pops));
    end

    // ---------------- per-job statistics ----------------
    int nc = 0, pop_cnt = 0, bad_pop = 0, cur_run = 0, max_run = 0;
    int done_cnt = 0, done_n = 0, last_pop_n = 0, start_n = 0;
    bit rd_s = 1'b0;
    logic [AW-1:0] wa_q[$];
    logic [RW-1:0] wd_q[$];

    always @(negedge clk) begin
        nc++;
        rd_s = fifo_rd;
        if (fifo_rd) begin
            pop_cnt++; last_pop_n = nc; cur_run++;
            if (!fifo_valid) bad_pop++;
            if (cur_run > max_run) max_run = cur_run;
        end else begin
            cur_run = 0;
        end
        if (!pmem_cen && !pmem_wen) begin
            wa_q.push_back(pmem_a);
            wd_q.push_back(pmem_d);
        end
        if (done) begin done_cnt++; done_n = nc; end
        if (start && !busy && reset) start_n = nc;
    end

    task automatic clr_stats();
        pop_cnt = 0; bad_pop = 0; cur_run = 0; max_run = 0;
        done_cnt = 0; done_n = 0; last_pop_n = 0; start_n = 0;
        wa_q.delete(); wd_q.delete();
    endtask

    // ---------------- FIFO stimulus ----------------
    logic [RW-1:0] fq[$];
    bit tmode = 1'b0;
    bit tog = 1'b0;

    task automatic tick();
        @(posedge clk); #1;
        if (rd_s && reset && fq.size() > 0) fq.delete(0);
        tog = ~tog;
        fifo_valid = (fq.size() > 0) && (!tmode || tog);
        fifo_out   = fifo_valid ? fq[0] : rnd_row();
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_cnt == 0 && k < 400) begin tick(); k++; end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        tick(); tick();
    endtask

    task automatic run_job(input int n, input int b, input bit tm);
        tmode = tm;
        clr_stats();
        num_rows = NW'(n); base_addr = AW'(b); start = 1'b1;
        tick();
        start = 1'b0;
        num_rows = NW'($urandom()); base_addr = AW'($urandom());
        wait_done();
    endtask

    task automatic chk_wr(input string nm, input int i, input logic [AW-1:0] ea, input logic [RW-1:0] ed);
        if (i >= wa_q.size()) begin
            checks++; errors++;
            $display("FAIL %s_missing actual=%0d writes required=%0d", nm, wa_q.size(), i + 1);
        end else begin
            chk($sformatf("%s_addr%0d", nm, i), RW'(wa_q[i]), RW'(ea));
            chk($sformatf("%s_data%0d", nm, i), wd_q[i], ed);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_fifo_rd"},   RW'(fifo_rd),   '0);
        chk({nm, "_pmem_cen"},  RW'(pmem_cen),  RW'(1));
        chk({nm, "_pmem_wen"},  RW'(pmem_wen),  RW'(1));
        chk({nm, "_pmem_a"},    RW'(pmem_a),    '0);
        chk({nm, "_pmem_d"},    pmem_d,         '0);
        chk({nm, "_busy"},      RW'(busy),      '0);
        chk({nm, "_done"},      RW'(done),      '0);
        chk({nm, "_rows_done"}, RW'(rows_done), '0);
    endtask

    int k;
    logic [RW-1:0] rrow, rexp, wrow;

    initial begin
        // T1: reset with random inputs
        repeat (3) begin
            @(posedge clk); #1;
            start = 1'($urandom()); num_rows = NW'($urandom()); base_addr = AW'($urandom());
            fifo_valid = 1'($urandom()); fifo_out = rnd_row();
        end
        chk_reset_vals("t1");
        start = 1'b0; fifo_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        tick();

        // T2: 8-row burst, base 0, valid held
        for (int i = 0; i < 8; i++) fq.push_back(mk_row(i * 16));
        run_job(8, 0, 1'b0);
        chki("t2_pops", pop_cnt, 8);
        chki("t2_consecutive", max_run, 8);
        chki("t2_writes", wa_q.size(), 8);
        for (int i = 0; i < 8; i++) chk_wr("t2", i, AW'(i), mk_row(i * 16));
        chki("t2_done_after_last_pop", done_n - last_pop_n, 2);
        chki("t2_done_pulses", done_cnt, 1);
        chki("t2_rows_done", int'(rows_done), 8);

        // T3: 4 rows with valid toggling
        for (int i = 0; i < 4; i++) fq.push_back(mk_row(1000 + i * 8));
        run_job(4, 3, 1'b1);
        chki("t3_pops", pop_cnt, 4);
        chki("t3_pop_while_invalid", bad_pop, 0);
        chki("t3_writes", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_wr("t3", i, AW'(3 + i), mk_row(1000 + i * 8));

        // T4: address wrap
        for (int i = 0; i < 4; i++) fq.push_back(mk_row(2000 + i * 8));
        run_job(4, 14, 1'b0);
        chk_wr("t4", 0, 4'd14, mk_row(2000));
        chk_wr("t4", 1, 4'd15, mk_row(2008));
        chk_wr("t4", 2, 4'd0,  mk_row(2016));
        chk_wr("t4", 3, 4'd1,  mk_row(2024));
        chki("t4_rows_done", int'(rows_done), 4);

        // T5: zero rows, second start while busy ignored
        clr_stats(); tmode = 1'b0;
        for (int i = 0; i < 3; i++) fq.push_back(mk_row(3000 + i));
        tick();
        num_rows = '0; base_addr = 4'd2; start = 1'b1;
        tick();
        num_rows = NW'(5); base_addr = 4'd7;
        tick();
        start = 1'b0;
        wait_done();
        chki("t5_pops", pop_cnt, 0);
        chki("t5_writes", wa_q.size(), 0);
        chki("t5_done_after_start", done_n - start_n, 1);
        chki("t5_done_pulses", done_cnt, 1);
        chki("t5_rows_done", int'(rows_done), 0);
        chki("t5_fifo_untouched", fq.size(), 3);
        fq.delete();

        // T6: reset after 3 writes of an 8-row job
        clr_stats(); tmode = 1'b0;
        for (int i = 0; i < 8; i++) fq.push_back(mk_row(4000 + i * 8));
        num_rows = NW'(8); base_addr = '0; start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (wa_q.size() < 3 && k < 100) begin tick(); k++; end
        chki("t6_three_writes", wa_q.size(), 3);
        reset = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        repeat (3) begin
            @(posedge clk); #1;
            start = 1'($urandom()); num_rows = NW'($urandom()); base_addr = AW'($urandom());
            fifo_valid = 1'($urandom()); fifo_out = rnd_row();
        end
        chk_reset_vals("t6_held");
        start = 1'b0; fifo_valid = 1'b0; fq.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        tick();

        // New job after abort, carrying a row with negative lanes
        rrow = mk_row(0);
        rrow[0*BW +: BW] = 20'hFFFFB;   // -5
        rrow[1*BW +: BW] = 20'd7;
        rrow[2*BW +: BW] = 20'h80000;   // most negative
        rrow[3*BW +: BW] = 20'h7FFFF;   // most positive
        rexp = rrow;
`ifdef RELU_EN
        rexp[0*BW +: BW] = '0;
        rexp[2*BW +: BW] = '0;
`endif
        fq.push_back(rrow);
        fq.push_back(mk_row(5000));
        run_job(2, 9, 1'b0);
        chki("t6_new_writes", wa_q.size(), 2);
        chk_wr("t6_new", 0, 4'd9, rexp);
        chk_wr("t6_new", 1, 4'd10, mk_row(5000));
        if (wd_q.size() > 0) begin
            wrow = wd_q[0];
`ifdef RELU_EN
            chk("t6_lane_neg5", RW'(wrow[0*BW +: BW]), '0);
`else
            chk("t6_lane_neg5", RW'(wrow[0*BW +: BW]), RW'(20'hFFFFB));
`endif
            chk("t6_lane_pos7", RW'(wrow[1*BW +: BW]), RW'(7));
        end
        chki("t6_rows_done", int'(rows_done), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
